psum_accumulator: RTL and testbench
===================================

# psum_accumulator

Per-column partial-sum accumulator downstream of the systolic MAC array. It receives the psum emerging from the bottom tile of one array column, one value per valid cycle. It accumulates those values across several kernel passes into a local register file, then drains the finished sums (optionally ReLU'd) to the output SRAM writer over a valid/ready handshake. One instance is used per array column.

## Interface
- psum_bw, 16, width of incoming psums and of each accumulator entry (signed two's complement)
- depth, 16, number of output positions held per accumulation group (power of 2, ≥2)
- pass_bw, 4, width of the pass-count input

- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low (0 = in reset); all state cleared immediately on assertion
- start  input  1  one-cycle pulse; begins a new group (honoured only in IDLE)
- num_pass  input  pass_bw  number of passes to accumulate; sampled on accepted start
- relu_en  input  1  clamp negative results to 0 on drain; sampled on accepted start
- in_psum  input  psum_bw  psum from the array column bottom
- in_valid  input  1  in_psum is valid this cycle
- out_data  output  psum_bw  drained result
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data this cycle
- busy  output  1  high in ACCUM or DRAIN
- done  output  1  one-cycle pulse when the last drain beat is accepted
- err  output  1  sticky: in_valid seen while not in ACCUM; cleared by accepted start

## Operation
- States: IDLE, ACCUM, DRAIN.
- IDLE → ACCUM on start. Latch num_pass (0 is treated as 1) and relu_en. Clear wptr, pass_cnt, rptr and err.
- ACCUM: each in_valid cycle updates acc[wptr].
  - Pass 0: acc[wptr] = in_psum (overwrite).
  - Later passes: acc[wptr] = sat(acc[wptr] + in_psum).
  - wptr increments mod depth. When wptr wraps from depth-1, pass_cnt increments.
- ACCUM → DRAIN on the in_valid beat that writes entry depth-1 of the final pass (pass_cnt == num_pass-1).
- in_valid low in ACCUM: no state change. Gaps of any length are legal.
- Saturation: compute the full sum at psum_bw+1 bits. Clamp to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
- DRAIN:
  - out_data = relu ? max(acc[rptr], 0) : acc[rptr].
  - out_valid high.
  - On out_valid && out_ready, rptr increments.
  - The beat at rptr == depth-1 returns the block to IDLE and pulses done.
- Ignored inputs:
  - start outside IDLE has no effect.
  - in_valid outside ACCUM is dropped and sets err.
  - Changes to num_pass or relu_en after start have no effect.
- Reset mid-operation: the block returns to IDLE. Accumulator contents are don't-care afterwards.

## Timing
- Reset values: out_valid=0, busy=0, done=0, err=0, out_data=0, state=IDLE.
- start at edge N: busy=1 from N+1. The first accepted in_valid is at edge N+1.
- Accumulate latency: acc update is visible one cycle after the in_valid edge. Back-to-back in_valid every cycle must be sustained, with no stalls.
- Final ACCUM beat at edge M: state=DRAIN and out_valid=1 after M. acc[0] appears on out_data in the same cycle.
- DRAIN throughput: one beat per cycle when out_ready is held high. depth beats take depth cycles minimum.
- out_valid may not drop, and out_data may not change, while out_ready=0 (standard valid/ready hold rule).
- done: high for exactly one cycle after the final accepted beat, coincident with busy=0 and out_valid=0.
- start in the same cycle as the done pulse is accepted, because the state is already IDLE.

## Test plan
- Single pass, depth=16, num_pass=1, in_psum = index 0..15 back-to-back, out_ready=1 → out_data 0..15 in order, done pulse after 16th beat, err=0.
- Three passes, each pass feeding 5 to all 16 entries with random in_valid gaps → 16 beats of 15. Then num_pass=0 with one pass of 7 → 16 beats of 7.
- Saturation, psum_bw=16, num_pass=2:
  - Entry 0 fed 30000 twice → 32767.
  - Entry 1 fed -30000 twice → -32768.
  - With relu_en=1 the drain gives entry 1 = 0 and entry 0 = 32767.
- Backpressure: toggle out_ready 1,0,0,1,… during DRAIN → out_data/out_valid stable while ready low, no beat lost or duplicated, 16 total.
- Protocol violations: in_valid in IDLE → err=1 and acc untouched. start during ACCUM → ignored, pass count unchanged. Next accepted start → err=0.
- Reset mid-DRAIN: reset=0 after beat 5 → out_valid=0 and busy=0 immediately (asynchronously). After release, a new start/single pass completes correctly.

Source files
------------

// File: rtl/psum_accumulator_if.sv
// Stream bundle between the MAC column, the psum accumulator and the SRAM writer.
// Handshake: a beat moves on a rising edge where valid && ready; once raised, valid and data hold until that edge.
interface psum_accumulator_if #(
  parameter int psum_bw = 16
) ();
  logic [psum_bw-1:0] in_psum;
  logic               in_valid;
  logic [psum_bw-1:0] out_data;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_psum, in_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  in_psum, in_valid, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/psum_accumulator.sv
// Per-column psum accumulator: sums depth-entry groups over num_pass passes with saturation,
// then drains them (optionally ReLU'd) over a valid/ready stream.
module psum_accumulator #(
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int pass_bw = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [pass_bw-1:0] num_pass,
  input  logic               relu_en,
  psum_accumulator_if.slave  bus,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         dbg_state
);
  localparam int ptr_bw = $clog2(depth);
  localparam logic [ptr_bw-1:0]  last_idx = ptr_bw'(depth - 1);
  localparam logic [psum_bw-1:0] sat_max  = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] sat_min  = {1'b1, {(psum_bw-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [ptr_bw-1:0]  wptr_q, wptr_d;
  logic [ptr_bw-1:0]  rptr_q, rptr_d;
  logic [pass_bw-1:0] pass_cnt_q, pass_cnt_d;
  logic [pass_bw-1:0] last_pass_q, last_pass_d;
  logic               relu_q, relu_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic [psum_bw-1:0] acc_q [depth];
  logic [psum_bw-1:0] acc_d;
  logic               acc_we;
  logic [psum_bw-1:0] acc_rd;
  logic [psum_bw-1:0] drain_rd;
  logic [psum_bw:0]   sum_ext;

  // One extra bit exposes overflow: the top two bits disagree exactly when the sum left range.
  always_comb begin
    acc_rd  = acc_q[wptr_q];
    sum_ext = {acc_rd[psum_bw-1], acc_rd} + {bus.in_psum[psum_bw-1], bus.in_psum};
    if (pass_cnt_q == '0) begin
      acc_d = bus.in_psum;
    end else if (sum_ext[psum_bw] != sum_ext[psum_bw-1]) begin
      acc_d = sum_ext[psum_bw] ? sat_min : sat_max;
    end else begin
      acc_d = sum_ext[psum_bw-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    pass_cnt_d  = pass_cnt_q;
    last_pass_d = last_pass_q;
    relu_d      = relu_q;
    err_d       = err_q;
    done_d      = 1'b0;
    acc_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ACCUM;
          last_pass_d = (num_pass == '0) ? '0 : num_pass - 1'b1;
          relu_d      = relu_en;
          wptr_d      = '0;
          rptr_d      = '0;
          pass_cnt_d  = '0;
          err_d       = 1'b0;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          acc_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (wptr_q == last_idx) begin
            if (pass_cnt_q == last_pass_q) state_d = DRAIN;
            else pass_cnt_d = pass_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          rptr_d = rptr_q + 1'b1;
          if (rptr_q == last_idx) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Stray input beats are dropped but remembered; a stray beat wins over a clearing start.
    if (bus.in_valid && state_q != ACCUM) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      pass_cnt_q  <= '0;
      last_pass_q <= '0;
      relu_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      pass_cnt_q  <= pass_cnt_d;
      last_pass_q <= last_pass_d;
      relu_q      <= relu_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  // Register file holds no reset: contents are meaningless until a group's first pass overwrites them.
  always_ff @(posedge clk) begin
    if (acc_we) acc_q[wptr_q] <= acc_d;
  end

  always_comb begin
    drain_rd      = acc_q[rptr_q];
    bus.out_valid = (state_q == DRAIN);
    bus.out_data  = '0;
    if (state_q == DRAIN) begin
      bus.out_data = (relu_q && drain_rd[psum_bw-1]) ? '0 : drain_rd;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized bench for psum_accumulator: a pass-by-pass arithmetic model fills an expected queue
// that is compared beat by beat against the drained stream.
module tb_psum_accumulator;
  localparam int depth = 16;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] num_pass;
  logic       relu_en;
  logic       busy, done, err;
  logic [1:0] dbg_state;

  psum_accumulator_if #(.psum_bw(16)) bus ();

  psum_accumulator #(.psum_bw(16), .depth(depth), .pass_bw(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_pass  (num_pass),
    .relu_en   (relu_en),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] pv [4][depth];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Reference: pass 0 loads, later passes add with clamping, drain applies optional ReLU.
  task automatic build_model(input int n_act, input bit relu);
    int m [depth];
    for (int p = 0; p < n_act; p++) begin
      for (int i = 0; i < depth; i++) begin
        int v;
        v = int'($signed(pv[p][i]));
        m[i] = (p == 0) ? v : sat16(m[i] + v);
      end
    end
    for (int i = 0; i < depth; i++) begin
      if (relu && m[i] < 0) exp_q.push_back(16'h0000);
      else exp_q.push_back(16'(m[i]));
    end
  endtask

  task automatic start_group(input logic [3:0] np, input bit relu);
    @(negedge clk);
    start    = 1'b1;
    num_pass = np;
    relu_en  = relu;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("err_cleared_by_start", err, 1'b0);
  endtask

  task automatic feed_pass(input int p, input int gap_max);
    for (int i = 0; i < depth; i++) begin
      int gap;
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (gap) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_psum  = 16'($urandom);
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_psum  = pv[p][i];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Called at the negedge right after the final accumulate beat.
  task automatic check_drain_entry();
    check("drain_valid_immediate", bus.out_valid, 1'b1);
    if (exp_q.size() > 0) check("drain_first_data", bus.out_data, exp_q[0]);
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,..., 2: random ready
  task automatic drain_beats(input int mode, input int n_beats);
    int          got;
    int          cyc;
    logic        held_v;
    logic [15:0] held_d;
    logic        rdy;
    got    = 0;
    cyc    = 0;
    held_v = 1'b0;
    held_d = '0;
    while (got < n_beats && cyc < 300) begin
      @(negedge clk);
      if (held_v) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_data", bus.out_data, held_d);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      if (bus.out_valid) begin
        if (rdy) begin
          check("drain_data", bus.out_data, exp_q.pop_front());
          got++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_d = bus.out_data;
        end
      end
      cyc++;
    end
    if (got < n_beats) check("drain_timeout_beats", got, n_beats);
  endtask

  task automatic finish_group(input int mode);
    check_drain_entry();
    drain_beats(mode, depth);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("done_pulse", done, 1'b1);
    check("busy_low_at_done", busy, 1'b0);
    check("valid_low_at_done", bus.out_valid, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
  endtask

  task automatic run_group(input logic [3:0] np, input bit relu, input int gap_max, input int mode);
    int n_act;
    n_act = (np == 0) ? 1 : int'(np);
    build_model(n_act, relu);
    start_group(np, relu);
    for (int p = 0; p < n_act; p++) feed_pass(p, gap_max);
    finish_group(mode);
  endtask

  task automatic fill_random(input int n_act);
    for (int p = 0; p < n_act; p++)
      for (int i = 0; i < depth; i++) pv[p][i] = 16'($urandom_range(0, 65535));
  endtask

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    num_pass      = '0;
    relu_en       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_psum   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_out_data", bus.out_data, 16'h0000);
    reset = 1'b1;

    // Single pass of the index ramp, back-to-back, ready held high.
    for (int i = 0; i < depth; i++) pv[0][i] = 16'(i);
    run_group(4'd1, 1'b0, 0, 0);
    check("err_after_clean_group", err, 1'b0);

    // Three passes of 5 with gaps, then num_pass=0 behaving as one pass of 7.
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < depth; i++) pv[p][i] = 16'd5;
    run_group(4'd3, 1'b0, 3, 2);
    for (int i = 0; i < depth; i++) pv[0][i] = 16'd7;
    run_group(4'd0, 1'b0, 2, 0);

    // Saturation at both rails, without and with ReLU.
    for (int r = 0; r < 2; r++) begin
      fill_random(2);
      pv[0][0] = 16'd30000;
      pv[1][0] = 16'd30000;
      pv[0][1] = 16'(-30000);
      pv[1][1] = 16'(-30000);
      run_group(4'd2, 1'(r), 1, (r == 0) ? 0 : 2);
    end

    // Backpressure with the 1,0,0 ready pattern.
    fill_random(1);
    run_group(4'd1, 1'b0, 0, 1);

    // Randomized groups.
    for (int g = 0; g < 6; g++) begin
      int np;
      np = $urandom_range(1, 3);
      fill_random(np);
      run_group(4'(np), 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Stray in_valid in IDLE sets sticky err.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_psum  = 16'h1234;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("err_set_in_idle", err, 1'b1);
    @(negedge clk);
    check("err_sticky", err, 1'b1);

    // Start during ACCUM with different settings must be ignored.
    fill_random(2);
    build_model(2, 1'b0);
    start_group(4'd2, 1'b0);
    feed_pass(0, 1);
    @(negedge clk);
    start    = 1'b1;
    num_pass = 4'd1;
    relu_en  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_ignored_start", busy, 1'b1);
    feed_pass(1, 1);
    finish_group(0);
    check("err_clear_after_group", err, 1'b0);

    // Reset in the middle of DRAIN, then a clean group.
    fill_random(1);
    build_model(1, 1'b0);
    start_group(4'd1, 1'b0);
    feed_pass(0, 0);
    check_drain_entry();
    drain_beats(0, 5);
    @(negedge clk);
    bus.out_ready = 1'b0;
    reset         = 1'b0;
    #1;
    check("async_reset_valid", bus.out_valid, 1'b0);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_data", bus.out_data, 16'h0000);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    fill_random(1);
    run_group(4'd1, 1'b1, 1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
